// File: rtl/i2c_pcf8574_target.sv
`timescale 1ns/1ps
// PCF8574-style I2C target: oversamples SCL/SDA with clk, latches written bytes onto
// o_port and returns i_port on reads. SDA is open-drain (drives only 0 or z).
module i2c_pcf8574_target #(
   parameter logic [6:0] ADDR = 7'h27
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       i_scl,
   inout  wire        io_sda,
   input  logic [7:0] i_port,
   output logic [7:0] o_port,
   output logic       o_wr,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_WR_DATA,
      S_WR_ACK,
      S_RD_DATA,
      S_RD_ACK
   } state_t;

   state_t     r_state;
   logic [1:0] r_sclSync;
   logic [1:0] r_sdaSync;
   logic       r_sclPrev;
   logic       r_sdaPrev;
   logic [3:0] r_bitCnt;
   logic [7:0] r_shift;
   logic       r_sdaOe;
   logic       r_rw;
   logic [7:0] r_port;
   logic       r_wr;
   logic       r_busy;

   state_t     w_stateNext;
   logic [3:0] w_bitCntNext;
   logic [7:0] w_shiftNext;
   logic       w_sdaOeNext;
   logic       w_rwNext;
   logic [7:0] w_portNext;
   logic       w_wrNext;
   logic       w_busyNext;

   logic       w_scl;
   logic       w_sda;
   logic       w_sclRise;
   logic       w_sclFall;
   logic       w_start;
   logic       w_stop;
   logic [7:0] w_byte;

   assign io_sda = r_sdaOe ? 1'b0 : 1'bz;

   assign w_scl     = r_sclSync[1];
   assign w_sda     = r_sdaSync[1];
   assign w_sclRise = w_scl & ~r_sclPrev;
   assign w_sclFall = ~w_scl & r_sclPrev;
   assign w_start   = ~w_sda & r_sdaPrev & w_scl & r_sclPrev;
   assign w_stop    = w_sda & ~r_sdaPrev & w_scl & r_sclPrev;
   assign w_byte    = {r_shift[6:0], w_sda};

   assign o_port = r_port;
   assign o_wr   = r_wr;
   assign o_busy = r_busy;

   // Synchronizers reset to the idle-bus level so reset release never looks like an edge.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_sclSync <= 2'b11;
         r_sdaSync <= 2'b11;
         r_sclPrev <= 1'b1;
         r_sdaPrev <= 1'b1;
      end else begin
         r_sclSync <= {r_sclSync[0], i_scl};
         r_sdaSync <= {r_sdaSync[0], io_sda};
         r_sclPrev <= r_sclSync[1];
         r_sdaPrev <= r_sdaSync[1];
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         r_state  <= S_IDLE;
         r_bitCnt <= 4'd0;
         r_shift  <= 8'h00;
         r_sdaOe  <= 1'b0;
         r_rw     <= 1'b0;
         r_port   <= 8'hFF;
         r_wr     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_bitCnt <= w_bitCntNext;
         r_shift  <= w_shiftNext;
         r_sdaOe  <= w_sdaOeNext;
         r_rw     <= w_rwNext;
         r_port   <= w_portNext;
         r_wr     <= w_wrNext;
         r_busy   <= w_busyNext;
      end
   end

   always_comb begin
      w_stateNext  = r_state;
      w_bitCntNext = r_bitCnt;
      w_shiftNext  = r_shift;
      w_sdaOeNext  = r_sdaOe;
      w_rwNext     = r_rw;
      w_portNext   = r_port;
      w_wrNext     = 1'b0;
      w_busyNext   = r_busy;

      if (w_start) begin
         w_stateNext  = S_ADDR;
         w_bitCntNext = 4'd0;
         w_sdaOeNext  = 1'b0;
      end else if (w_stop) begin
         w_stateNext  = S_IDLE;
         w_bitCntNext = 4'd0;
         w_sdaOeNext  = 1'b0;
         w_busyNext   = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_sdaOeNext = 1'b0;
            end

            S_ADDR: begin
               if (w_sclRise) begin
                  w_shiftNext = w_byte;
                  if (r_bitCnt == 4'd7) begin
                     w_bitCntNext = 4'd0;
                     if (w_byte[7:1] == ADDR) begin
                        w_stateNext = S_ADDR_ACK;
                        w_busyNext  = 1'b1;
                        w_rwNext    = w_byte[0];
                        if (w_byte[0]) begin
                           w_shiftNext = i_port;
                        end
                     end else begin
                        w_stateNext = S_IDLE;
                        w_busyNext  = 1'b0;
                        w_sdaOeNext = 1'b0;
                     end
                  end else begin
                     w_bitCntNext = r_bitCnt + 4'd1;
                  end
               end
            end

            // Ack states enter with SDA released: first SCL fall pulls low, second releases.
            S_ADDR_ACK: begin
               if (w_sclFall) begin
                  if (!r_sdaOe) begin
                     w_sdaOeNext = 1'b1;
                  end else if (r_rw) begin
                     w_stateNext  = S_RD_DATA;
                     w_sdaOeNext  = ~r_shift[7];
                     w_shiftNext  = {r_shift[6:0], 1'b0};
                     w_bitCntNext = 4'd1;
                  end else begin
                     w_stateNext  = S_WR_DATA;
                     w_sdaOeNext  = 1'b0;
                     w_bitCntNext = 4'd0;
                  end
               end
            end

            S_WR_DATA: begin
               if (w_sclRise) begin
                  w_shiftNext = w_byte;
                  if (r_bitCnt == 4'd7) begin
                     w_stateNext  = S_WR_ACK;
                     w_bitCntNext = 4'd0;
                     w_portNext   = w_byte;
                     w_wrNext     = 1'b1;
                  end else begin
                     w_bitCntNext = r_bitCnt + 4'd1;
                  end
               end
            end

            S_WR_ACK: begin
               if (w_sclFall) begin
                  if (!r_sdaOe) begin
                     w_sdaOeNext = 1'b1;
                  end else begin
                     w_stateNext  = S_WR_DATA;
                     w_sdaOeNext  = 1'b0;
                     w_bitCntNext = 4'd0;
                  end
               end
            end

            // r_bitCnt counts bits already placed on SDA; the fall after the 8th frees the bus.
            S_RD_DATA: begin
               if (w_sclFall) begin
                  if (r_bitCnt == 4'd8) begin
                     w_stateNext  = S_RD_ACK;
                     w_sdaOeNext  = 1'b0;
                     w_bitCntNext = 4'd0;
                  end else begin
                     w_sdaOeNext  = ~r_shift[7];
                     w_shiftNext  = {r_shift[6:0], 1'b0};
                     w_bitCntNext = r_bitCnt + 4'd1;
                  end
               end
            end

            S_RD_ACK: begin
               if (w_sclRise) begin
                  if (!w_sda) begin
                     w_stateNext  = S_RD_DATA;
                     w_shiftNext  = i_port;
                     w_bitCntNext = 4'd0;
                  end else begin
                     w_stateNext = S_IDLE;
                     w_busyNext  = 1'b0;
                     w_sdaOeNext = 1'b0;
                  end
               end
            end

            default: begin
               w_stateNext = S_IDLE;
               w_sdaOeNext = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_pcf8574_target.sv
`timescale 1ns/1ps
// Bench for i2c_pcf8574_target: a bit-banged I2C master plus a transaction-level
// model of the expander (expected port value, write log, read data).
module tb_i2c_pcf8574_target;

   localparam int Q = 5;

   logic       clk = 1'b0;
   logic       reset_p;
   logic       scl;
   logic       mLow;
   logic [7:0] portIn;
   wire        sda;
   wire  [7:0] portOut;
   wire        wrStrobe;
   wire        busy;

   int checkCount = 0;
   int passCount = 0;
   int failCount = 0;
   int cyc = 0;
   int lastRiseCyc = 0;
   int wrCount = 0;
   int wrHighCycles = 0;
   logic prevWr = 1'b0;
   logic dutLowSeen = 1'b0;
   logic [7:0] wrLog[$];
   logic [7:0] expLog[$];
   logic [7:0] expPort;

   pullup (sda);
   assign sda = mLow ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   i2c_pcf8574_target #(.ADDR(7'h27)) dut (
      .clk     (clk),
      .reset_p (reset_p),
      .i_scl   (scl),
      .io_sda  (sda),
      .i_port  (portIn),
      .o_port  (portOut),
      .o_wr    (wrStrobe),
      .o_busy  (busy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // SDA low while the master is released can only be the target pulling it.
   always @(posedge clk) begin
      if (!mLow && sda === 1'b0) dutLowSeen = 1'b1;
   end

   always @(negedge clk) begin
      if (wrStrobe === 1'b1) begin
         wrHighCycles++;
         if (!prevWr) begin
            wrCount++;
            wrLog.push_back(portOut);
            checkOutput("wrLatency", cyc - lastRiseCyc, 3);
         end
      end
      prevWr = wrStrobe;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitQ();
      repeat (Q) @(negedge clk);
   endtask

   task automatic busStart();
      waitQ(); mLow = 1'b1;
      waitQ(); scl = 1'b0;
   endtask

   task automatic busRestart();
      waitQ(); mLow = 1'b0;
      waitQ(); scl = 1'b1;
      waitQ(); mLow = 1'b1;
      waitQ(); scl = 1'b0;
   endtask

   task automatic busStop();
      waitQ(); mLow = 1'b1;
      waitQ(); scl = 1'b1;
      waitQ(); mLow = 1'b0;
      waitQ();
   endtask

   task automatic sendBit(input logic b);
      waitQ(); mLow = ~b;
      waitQ(); scl = 1'b1; lastRiseCyc = cyc;
      waitQ();
      waitQ(); scl = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) sendBit(b[i]);
      waitQ(); mLow = 1'b0;
      waitQ(); scl = 1'b1;
      waitQ(); ack = sda;
      waitQ(); scl = 1'b0;
   endtask

   task automatic readByte(output logic [7:0] got, input logic nack, input logic [7:0] nextPort);
      for (int i = 7; i >= 0; i--) begin
         waitQ();
         waitQ(); scl = 1'b1;
         waitQ(); got[i] = sda;
         waitQ(); scl = 1'b0;
      end
      waitQ(); mLow = ~nack; portIn = nextPort;
      waitQ(); scl = 1'b1;
      waitQ();
      waitQ(); scl = 1'b0;
      waitQ(); mLow = 1'b0;
   endtask

   // Full write transaction; the model only updates when the address targets us.
   task automatic applyStimulus(input logic [7:0] addrByte, input logic [7:0] data [4], input int n);
      logic ack;
      logic match;
      match = (addrByte[7:1] == 7'h27) && !addrByte[0];
      busStart();
      sendByte(addrByte, ack);
      checkOutput("addrAck", ack, match ? 0 : 1);
      checkOutput("busyAfterAddr", busy, match);
      for (int i = 0; i < n; i++) begin
         sendByte(data[i], ack);
         checkOutput("dataAck", ack, match ? 0 : 1);
         if (match) begin
            expPort = data[i];
            expLog.push_back(data[i]);
         end
      end
      busStop();
      checkOutput("busyAfterStop", busy, 0);
      checkOutput("portAfterWrite", portOut, expPort);
      checkOutput("wrCount", wrCount, expLog.size());
   endtask

   task automatic readTransaction(input logic [7:0] ports [4], input int n);
      logic ack;
      logic last;
      logic [7:0] got;
      portIn = ports[0];
      busStart();
      sendByte(8'h4F, ack);
      checkOutput("readAddrAck", ack, 0);
      checkOutput("busyRead", busy, 1);
      for (int i = 0; i < n; i++) begin
         last = (i == n - 1);
         readByte(got, last, last ? ports[i] : ports[i + 1]);
         checkOutput("readData", got, ports[i]);
      end
      checkOutput("busyAfterNack", busy, 0);
      checkOutput("sdaAfterNack", sda, 1);
      busStop();
   endtask

   initial begin
      logic [7:0] data [4];
      logic [7:0] ports [4];
      logic [6:0] a;
      logic ack;
      int n;

      reset_p = 1'b1;
      scl     = 1'b1;
      mLow    = 1'b0;
      portIn  = 8'h00;
      expPort = 8'hFF;
      repeat (3) @(negedge clk);
      reset_p = 1'b0;
      @(negedge clk);
      checkOutput("resetPort", portOut, 8'hFF);
      checkOutput("resetWr", wrStrobe, 0);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetSda", sda, 1);

      $display("[TB] single write 0x5A");
      data = '{8'h5A, 8'h00, 8'h00, 8'h00};
      applyStimulus(8'h4E, data, 1);

      $display("[TB] address mismatch");
      dutLowSeen = 1'b0;
      data = '{8'h12, 8'h00, 8'h00, 8'h00};
      applyStimulus(8'h40, data, 1);
      checkOutput("mismatchNoDrive", dutLowSeen, 0);

      $display("[TB] read 0xC3 with NACK");
      ports = '{8'hC3, 8'h00, 8'h00, 8'h00};
      readTransaction(ports, 1);

      $display("[TB] CLCD burst");
      data = '{8'h0C, 8'h08, 8'h3C, 8'h00};
      applyStimulus(8'h4E, data, 3);

      $display("[TB] repeated START mid-byte");
      busStart();
      sendByte(8'h4E, ack);
      checkOutput("rsAddrAck", ack, 0);
      sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b0);
      busRestart();
      sendByte(8'h4E, ack);
      checkOutput("rsAddrAck2", ack, 0);
      sendByte(8'h11, ack);
      checkOutput("rsDataAck", ack, 0);
      expPort = 8'h11;
      expLog.push_back(8'h11);
      busStop();
      checkOutput("rsPort", portOut, expPort);
      checkOutput("rsWrCount", wrCount, expLog.size());

      $display("[TB] reset during a driven ACK");
      busStart();
      for (int i = 7; i >= 0; i--) sendBit(n[0] | 1'b0 ? 1'b0 : ((8'h4E >> i) & 1));
      waitQ(); mLow = 1'b0;
      waitQ(); scl = 1'b1;
      waitQ();
      checkOutput("ackHeldLow", sda, 0);
      reset_p = 1'b1;
      #1;
      checkOutput("resetReleasesSda", sda, 1);
      repeat (2) @(negedge clk);
      reset_p = 1'b0;
      expPort = 8'hFF;
      @(negedge clk);
      checkOutput("portAfterReset", portOut, 8'hFF);
      checkOutput("busyAfterReset", busy, 0);
      data = '{8'h77, 8'h00, 8'h00, 8'h00};
      applyStimulus(8'h4E, data, 1);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 8; t++) begin
         n = $urandom_range(1, 3);
         if ($urandom_range(0, 2) != 0) begin
            for (int i = 0; i < 4; i++) data[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
               a = 7'($urandom_range(0, 127));
               if (a == 7'h27) a = 7'h20;
               applyStimulus({a, 1'b0}, data, n);
            end else begin
               applyStimulus(8'h4E, data, n);
            end
         end else begin
            for (int i = 0; i < 4; i++) ports[i] = 8'($urandom);
            readTransaction(ports, n);
         end
      end

      checkOutput("wrPulseWidth", wrHighCycles, wrCount);
      checkOutput("wrLogSize", wrLog.size(), expLog.size());
      for (int i = 0; i < expLog.size() && i < wrLog.size(); i++) begin
         checkOutput("wrLogEntry", wrLog[i], expLog[i]);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
